ring_period_monitor: RTL

RING_PERIOD_MONITOR -- requirements
Module: ring_period_monitor

---
 rtl/ring_period_monitor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ring_period_monitor.sv
`default_nettype none
// ring_period_monitor: measures the period of per-channel ring acknowledge
// edges, keeps last/min/max/count statistics, flags stalls and saturation.
// Revision: 1.0
module ring_period_monitor #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000,
    localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   la,
    input  logic             en,
    input  logic             clr,
    input  logic [SEL_W-1:0] sel,
    output logic [NCH-1:0]   sample,
    output logic [NCH-1:0]   stalled,
    output logic [NCH-1:0]   ovf,
    output logic [CNT_W-1:0] rd_last,
    output logic [CNT_W-1:0] rd_min,
    output logic [CNT_W-1:0] rd_max,
    output logic [7:0]       rd_count
);

    localparam logic [1:0]       ST_IDLE    = 2'd0;
    localparam logic [1:0]       ST_ARMED   = 2'd1;
    localparam logic [1:0]       ST_STALLED = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [2:0]       WARM       = 3'(SYNC_STAGES + 1);

    logic [2:0] r_warm;
    logic       w_warm;

    logic [CNT_W-1:0] w_last  [NCH];
    logic [CNT_W-1:0] w_min   [NCH];
    logic [CNT_W-1:0] w_max   [NCH];
    logic [7:0]       w_count [NCH];

    // Edge detection stays off until the synchroniser and previous-value flop
    // hold real samples, so a level already high at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm <= 3'd0;
        end else if (r_warm != WARM) begin
            r_warm <= r_warm + 3'd1;
        end
    end

    assign w_warm = (r_warm == WARM);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_prev;
        logic                   w_edge;
        logic                   w_timeout;
        logic [1:0]             r_state;
        logic [1:0]             w_next;
        logic                   w_record;
        logic                   w_inc;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_period;
        logic [CNT_W-1:0]       r_last;
        logic [CNT_W-1:0]       r_min;
        logic [CNT_W-1:0]       r_max;
        logic [7:0]             r_count;
        logic                   r_sample;
        logic                   r_ovf;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
                r_prev <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], la[g]};
                r_prev <= r_sync[SYNC_STAGES-1];
            end
        end

        assign w_edge    = w_warm & r_sync[SYNC_STAGES-1] & ~r_prev;
        assign w_timeout = (64'(r_cnt) == 64'(TIMEOUT));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
            end else if (clr || !en) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_next;
            end
        end

        always_comb begin
            w_next = r_state;
            case (r_state)
                ST_IDLE:    if (w_edge) w_next = ST_ARMED;
                ST_ARMED:   if (!w_edge && w_timeout) w_next = ST_STALLED;
                ST_STALLED: if (w_edge) w_next = ST_ARMED;
                default:    w_next = ST_IDLE;
            endcase
        end

        always_comb begin
            w_record = 1'b0;
            w_inc    = 1'b0;
            if (r_state == ST_ARMED && en && !clr) begin
                w_record = w_edge;
                w_inc    = !w_edge && (r_cnt != CNT_MAX);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (clr || !en || w_edge) begin
                r_cnt <= '0;
            end else if (w_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        // Counter value is one short of the edge distance; a saturated counter
        // reports the saturated value itself.
        assign w_period = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_last   <= '0;
                r_min    <= CNT_MAX;
                r_max    <= '0;
                r_count  <= 8'd0;
                r_sample <= 1'b0;
                r_ovf    <= 1'b0;
            end else if (clr) begin
                r_last   <= '0;
                r_min    <= CNT_MAX;
                r_max    <= '0;
                r_count  <= 8'd0;
                r_sample <= 1'b0;
                r_ovf    <= 1'b0;
            end else begin
                r_sample <= w_record;
                if (w_record) begin
                    r_last <= w_period;
                    if (w_period < r_min) r_min <= w_period;
                    if (w_period > r_max) r_max <= w_period;
                    if (r_count != 8'hFF) r_count <= r_count + 8'd1;
                    if (w_period == CNT_MAX) r_ovf <= 1'b1;
                end
            end
        end

        assign sample[g]  = r_sample;
        assign stalled[g] = (r_state == ST_STALLED);
        assign ovf[g]     = r_ovf;
        assign w_last[g]  = r_last;
        assign w_min[g]   = r_min;
        assign w_max[g]   = r_max;
        assign w_count[g] = r_count;
    end

    // Out-of-range selects fall through to channel 0.
    always_comb begin
        rd_last  = w_last[0];
        rd_min   = w_min[0];
        rd_max   = w_max[0];
        rd_count = w_count[0];
        for (int i = 1; i < NCH; i++) begin
            if (32'(sel) == i) begin
                rd_last  = w_last[i];
                rd_min   = w_min[i];
                rd_max   = w_max[i];
                rd_count = w_count[i];
            end
        end
    end

endmodule
`default_nettype wire
